data_mem_stack: RTL and testbench
=================================

// Module: data_mem_stack
// PURPOSE
//  Parametrised data memory with a built-in hardware stack engine; next generation of the 8-bit DataMEM.
//  - Stack pointer, depth tracking and overflow/underflow detection move inside the memory.
//  - Pipeline MEM stage issues plain loads/stores plus Push/Pop (CALL/RET/PUSH/POP); no external SP arithmetic.
//  - One port set serves data accesses; the stack region occupies the top STACK_DEPTH words.
// PARAMETERS
//  DATA_W       8    data word width (bits)
//  ADDR_W       8    address width; memory holds 2**ADDR_W words
//  STACK_DEPTH  32   max stack entries, 1..2**ADDR_W-1
// PORTS
//  Clk       in   1       clock, all state updates on rising edge
//  Rst       in   1       asynchronous reset, active-high
//  WE        in   1       data-port write enable
//  A         in   ADDR_W  data-port address
//  WD        in   DATA_W  data-port write data
//  RD        out  DATA_W  data-port read data, mem[A]
//  Push      in   1       push PushData onto stack
//  Pop       in   1       pop top of stack
//  PushData  in   DATA_W  value to push
//  X         out  DATA_W  top-of-stack value, mem[Sp+1]
//  Sp        out  ADDR_W  stack pointer (next free slot)
//  Full      out  1       Depth == STACK_DEPTH
//  Empty     out  1       Depth == 0
//  Ovf       out  1       sticky: push attempted while Full
//  Unf       out  1       sticky: pop attempted while Empty
//  Clash     out  1       1-cycle pulse: data write dropped, same-address stack write
//  ErrClr    in   1       synchronous clear of Ovf/Unf
// BEHAVIOUR
//  Reset (async, Rst=1):
//   - Sp=2**ADDR_W-1, Depth=0, Empty=1, Full=0, Ovf=0, Unf=0, Clash=0.
//   - Memory array not cleared.
//  Stack convention: empty-descending; Sp = next free word, top = mem[Sp+1]; ADDR_W-bit wrap for Sp+1.
//  Stack operations per cycle:
//   - Push only, !Full: mem[Sp]<=PushData; Sp<=Sp-1; Depth+1.
//   - Push only, Full: no write, Sp/Depth hold, Ovf<=1.
//   - Pop only, !Empty: Sp<=Sp+1; Depth-1; memory untouched.
//   - Pop only, Empty: Sp/Depth hold, Unf<=1.
//   - Push&Pop, !Empty: replace top, mem[Sp+1]<=PushData; Sp/Depth hold; no flags.
//   - Push&Pop, Empty: executes as push; Unf<=1.
//  Data port:
//   - WE=1 writes mem[A]<=WD at the edge.
//   - Same-cycle stack write to a different address: both writes land.
//   - Same address: stack wins, data write dropped, Clash=1 for that one cycle.
//  Flags:
//   - Full/Empty derive combinationally from the Depth register.
//   - ErrClr=1 clears Ovf/Unf; a new error in the same cycle wins (flag stays 1).
//  Reads:
//   - X always reflects current mem[Sp+1]; X is undefined-but-stable when Empty.
//   - Read during write returns old contents until the edge.
//  Reset mid-operation: in-flight push/pop discarded; pointer and flags return to reset values.
// CONFIGURATION
//  DMEM_REG_RD_EN defined:
//   - RD and X registered, 1-cycle latency, read-first (old data on same-address write).
//   - Both registers reset to 0.
//  DMEM_REG_RD_EN undefined:
//   - RD and X combinational, 0-cycle latency, as the single-cycle DataMEM.
// TESTING (DATA_W=8, ADDR_W=8, STACK_DEPTH=4, combinational reads)
//  Reset -> Sp=0xFF, Empty=1, Full=0, Ovf=Unf=0.
//  Push 0x11,0x22,0x33,0x44 -> Sp=0xFB, Full=1, X=0x44; 5th push 0x55 -> Ovf=1, mem[0xFB] unchanged.
//  Pop x4 -> X sequence 0x44,0x33,0x22,0x11, Empty=1; 5th pop -> Unf=1, Sp=0xFF; ErrClr -> Ovf=Unf=0.
//  Depth 2 (X=0x22), Push&Pop with 0x99 -> X=0x99, Sp=0xFD, Depth stays 2.
//  Sp=0xFF, WE A=0xFF WD=0xAA plus Push 0x77 -> mem[0xFF]=0x77, Clash=1 for one cycle.
//  DMEM_REG_RD_EN: write mem[0x10]=0x5A, read A=0x10 -> RD=0x5A one cycle after A applied.

Source files
------------

// File: rtl/data_mem_stack_if.sv
// Data-port and stack-engine signal bundle for data_mem_stack.
interface data_mem_stack_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              WE;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] RD;
  logic              Push;
  logic              Pop;
  logic [DATA_W-1:0] PushData;
  logic [DATA_W-1:0] X;
  logic [ADDR_W-1:0] Sp;
  logic              Full;
  logic              Empty;
  logic              Ovf;
  logic              Unf;
  logic              Clash;
  logic              ErrClr;

  modport master (
    output WE, A, WD, Push, Pop, PushData, ErrClr,
    input  RD, X, Sp, Full, Empty, Ovf, Unf, Clash
  );

  modport slave (
    input  WE, A, WD, Push, Pop, PushData, ErrClr,
    output RD, X, Sp, Full, Empty, Ovf, Unf, Clash
  );
endinterface

// File: rtl/data_mem_stack.sv
// Data memory with an empty-descending hardware stack in its top STACK_DEPTH words.
// Define DMEM_REG_RD_EN for registered (1-cycle, read-first) RD/X; default is combinational reads.
module data_mem_stack #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 32
) (
  input  logic Clk,
  input  logic Rst,
  data_mem_stack_if.slave bus
);

  localparam int unsigned WORDS   = 2 ** ADDR_W;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [DATA_W-1:0]  mem [WORDS];
  logic [ADDR_W-1:0]  sp_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               ovf_q;
  logic               unf_q;
  logic               clash_q;

  logic [ADDR_W-1:0]  top_addr;
  logic [ADDR_W-1:0]  stk_addr;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;
  logic               replace;
  logic               stk_we;
  logic               data_we;
  logic               ovf_set;
  logic               unf_set;
  logic               clash_d;

  // Stack operation decode; push+pop on an empty stack degrades to a plain push.
  always_comb begin
    top_addr = sp_q + ADDR_W'(1);
    full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    empty    = (depth_q == '0);
    replace  = bus.Push & bus.Pop & ~empty;
    do_push  = bus.Push & ~full & (~bus.Pop | empty);
    do_pop   = bus.Pop & ~bus.Push & ~empty;
    ovf_set  = bus.Push & ~bus.Pop & full;
    unf_set  = bus.Pop & empty;
    stk_we   = (do_push | replace) & ~Rst;
    stk_addr = replace ? top_addr : sp_q;
    clash_d  = bus.WE & stk_we & (stk_addr == bus.A);
    data_we  = bus.WE & ~clash_d;
  end

  // Pointer, depth and error flags.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sp_q    <= '1;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      clash_q <= 1'b0;
    end else begin
      if (do_push) begin
        sp_q    <= sp_q - ADDR_W'(1);
        depth_q <= depth_q + DEPTH_W'(1);
      end else if (do_pop) begin
        sp_q    <= top_addr;
        depth_q <= depth_q - DEPTH_W'(1);
      end
      ovf_q   <= ovf_set | (ovf_q & ~bus.ErrClr);
      unf_q   <= unf_set | (unf_q & ~bus.ErrClr);
      clash_q <= clash_d;
    end
  end

  // Storage is never reset; a colliding data write is suppressed in decode.
  always_ff @(posedge Clk) begin
    if (data_we) mem[bus.A] <= bus.WD;
    if (stk_we)  mem[stk_addr] <= bus.PushData;
  end

`ifdef DMEM_REG_RD_EN
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] x_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_q <= '0;
      x_q  <= '0;
    end else begin
      rd_q <= mem[bus.A];
      x_q  <= mem[top_addr];
    end
  end

  assign bus.RD = rd_q;
  assign bus.X  = x_q;
`else
  assign bus.RD = mem[bus.A];
  assign bus.X  = mem[top_addr];
`endif

  assign bus.Sp    = sp_q;
  assign bus.Full  = full;
  assign bus.Empty = empty;
  assign bus.Ovf   = ovf_q;
  assign bus.Unf   = unf_q;
  assign bus.Clash = clash_q;

endmodule

// File: tb/tb_data_mem_stack.sv
// Directed self-checking bench for data_mem_stack (DATA_W=8, ADDR_W=8, STACK_DEPTH=4).
module tb_data_mem_stack;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_total  = 0;
  int   n_passed = 0;
  int   n_failed = 0;

  data_mem_stack_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  data_mem_stack #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.WE = 1'b0; bus.Push = 1'b0; bus.Pop = 1'b0; bus.ErrClr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.Push = 1'b1; bus.PushData = d;
    tick();
    idle();
  endtask

  task automatic pop();
    bus.Pop = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bus.A = addr;
`ifdef DMEM_REG_RD_EN
    tick();
`else
    #1;
`endif
    chk(tag, 32'(bus.RD), 32'(exp));
  endtask

  initial begin
    logic [7:0] xseq [4];
    xseq[0] = 8'h44; xseq[1] = 8'h33; xseq[2] = 8'h22; xseq[3] = 8'h11;
    idle();
    bus.A = '0; bus.WD = '0; bus.PushData = '0;

    // Reset state
    tick(); tick();
    chk("rst_sp",    32'(bus.Sp),    32'hFF);
    chk("rst_empty", 32'(bus.Empty), 32'd1);
    chk("rst_full",  32'(bus.Full),  32'd0);
    chk("rst_ovf",   32'(bus.Ovf),   32'd0);
    chk("rst_unf",   32'(bus.Unf),   32'd0);
    chk("rst_clash", 32'(bus.Clash), 32'd0);
    Rst = 1'b0;
    tick();

    // Seed mem[0xFB] so the overflow push can be shown to leave it alone
    bus.WE = 1'b1; bus.A = 8'hFB; bus.WD = 8'hC3;
    tick();
    idle();
    rd_check("seed_fb", 8'hFB, 8'hC3);

    // Fill to Full
    push(8'h11); chk("x_after_p1", 32'(bus.X), 32'h11);
    push(8'h22); chk("x_after_p2", 32'(bus.X), 32'h22);
    push(8'h33); chk("x_after_p3", 32'(bus.X), 32'h33);
    push(8'h44);
    chk("fill_sp",    32'(bus.Sp),    32'hFB);
    chk("fill_full",  32'(bus.Full),  32'd1);
    chk("fill_empty", 32'(bus.Empty), 32'd0);
    chk("fill_x",     32'(bus.X),     32'h44);

    // Overflow
    push(8'h55);
    chk("ovf_flag", 32'(bus.Ovf), 32'd1);
    chk("ovf_sp",   32'(bus.Sp),  32'hFB);
    chk("ovf_x",    32'(bus.X),   32'h44);
    rd_check("ovf_mem_fb", 8'hFB, 8'hC3);

    // Drain, X seen before each pop
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop_x%0d", i), 32'(bus.X), 32'(xseq[i]));
      pop();
    end
    chk("drain_empty", 32'(bus.Empty), 32'd1);
    chk("drain_sp",    32'(bus.Sp),    32'hFF);

    // Underflow, then clear with a simultaneous new underflow (new error wins)
    pop();
    chk("unf_flag", 32'(bus.Unf), 32'd1);
    chk("unf_sp",   32'(bus.Sp),  32'hFF);
    chk("unf_ovf_sticky", 32'(bus.Ovf), 32'd1);
    bus.ErrClr = 1'b1; bus.Pop = 1'b1;
    tick(); idle();
    chk("clr_new_unf", 32'(bus.Unf), 32'd1);
    chk("clr_ovf",     32'(bus.Ovf), 32'd0);
    bus.ErrClr = 1'b1;
    tick(); idle();
    chk("clr_unf", 32'(bus.Unf), 32'd0);

    // Replace top at depth 2
    push(8'h11); push(8'h22);
    chk("d2_x", 32'(bus.X), 32'h22);
    bus.Push = 1'b1; bus.Pop = 1'b1; bus.PushData = 8'h99;
    tick(); idle();
    chk("repl_x",   32'(bus.X),   32'h99);
    chk("repl_sp",  32'(bus.Sp),  32'hFD);
    chk("repl_unf", 32'(bus.Unf), 32'd0);
    chk("repl_ovf", 32'(bus.Ovf), 32'd0);
    pop();
    chk("repl_pop_x",  32'(bus.X),  32'h11);
    chk("repl_pop_sp", 32'(bus.Sp), 32'hFE);
    pop();
    chk("repl_depth2_empty", 32'(bus.Empty), 32'd1);

    // Push&Pop on empty acts as a push and flags underflow
    bus.Push = 1'b1; bus.Pop = 1'b1; bus.PushData = 8'h66;
    tick(); idle();
    chk("pp_empty_x",   32'(bus.X),   32'h66);
    chk("pp_empty_sp",  32'(bus.Sp),  32'hFE);
    chk("pp_empty_unf", 32'(bus.Unf), 32'd1);
    pop();
    bus.ErrClr = 1'b1;
    tick(); idle();

    // Same-address collision: stack wins, Clash pulses once
    bus.WE = 1'b1; bus.A = 8'hFF; bus.WD = 8'hAA;
    bus.Push = 1'b1; bus.PushData = 8'h77;
    tick(); idle();
    chk("clash_pulse", 32'(bus.Clash), 32'd1);
    chk("clash_x",     32'(bus.X),     32'h77);
    tick();
    chk("clash_drop",  32'(bus.Clash), 32'd0);
    rd_check("clash_mem_ff", 8'hFF, 8'h77);

    // Different addresses: both writes land
    bus.WE = 1'b1; bus.A = 8'h20; bus.WD = 8'h5A;
    bus.Push = 1'b1; bus.PushData = 8'h88;
    tick(); idle();
    chk("both_clash", 32'(bus.Clash), 32'd0);
    chk("both_x",     32'(bus.X),     32'h88);
    chk("both_sp",    32'(bus.Sp),    32'hFD);
    rd_check("both_mem_20", 8'h20, 8'h5A);

    // Reset mid-operation discards the push
    bus.Push = 1'b1; bus.PushData = 8'h12;
    #2 Rst = 1'b1;
    tick(); idle();
    chk("midrst_sp",    32'(bus.Sp),    32'hFF);
    chk("midrst_empty", 32'(bus.Empty), 32'd1);
    Rst = 1'b0;
    tick();
    chk("midrst_sp_hold", 32'(bus.Sp), 32'hFF);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
